// File: rtl/uart_tx_arbiter_if.sv
// Bundle between a set of byte producers, the round-robin arbiter and one UART transmitter.
// The arbiter takes the slave modport; the producer/transmitter side takes the master modport.
interface uart_tx_arbiter_if #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = $clog2(NumReq)
);
    logic [NumReq-1:0]   req;
    logic [8*NumReq-1:0] req_data;
    logic [NumReq-1:0]   req_par_en;
    logic [NumReq-1:0]   req_par_typ;
    logic                tx_busy;
    logic [NumReq-1:0]   ack;
    logic                tx_dv;
    logic [7:0]          tx_data;
    logic                tx_par_en;
    logic                tx_par_typ;
    logic [IdxW-1:0]     owner;
    logic                active;
    logic                err_timeout;

    modport slave (
        input  req, req_data, req_par_en, req_par_typ, tx_busy,
        output ack, tx_dv, tx_data, tx_par_en, tx_par_typ, owner, active, err_timeout
    );

    modport master (
        output req, req_data, req_par_en, req_par_typ, tx_busy,
        input  ack, tx_dv, tx_data, tx_par_en, tx_par_typ, owner, active, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NumReq byte producers.
// Launches one frame at a time and abandons a launch if busy never rises.
module uart_tx_arbiter #(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned IdxW    = $clog2(NumReq),
    parameter int unsigned Timeout = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(Timeout);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StWaitBusy = 2'd1;
    localparam logic [1:0] StWaitDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumReq-1:0] ack_q, ack_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_par_en_q, tx_par_en_d;
    logic              tx_par_typ_q, tx_par_typ_d;
    logic              active_q, active_d;
    logic              err_q, err_d;

    logic              grant_found;
    logic [IdxW-1:0]   winner;
    logic [IdxW-1:0]   cand;
    logic [7:0]        win_data;
    logic              win_par_en;
    logic              win_par_typ;

    // First pending requester scanning upward from ptr+1 with wrap.
    always_comb begin
        grant_found = 1'b0;
        winner      = ptr_q;
        cand        = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NumReq);
            if (!grant_found && bus.req[cand]) begin
                grant_found = 1'b1;
                winner      = cand;
            end
        end
    end

    always_comb begin
        win_data    = '0;
        win_par_en  = 1'b0;
        win_par_typ = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (winner == IdxW'(i)) begin
                win_data    = bus.req_data[8*i +: 8];
                win_par_en  = bus.req_par_en[i];
                win_par_typ = bus.req_par_typ[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        tx_dv_d      = 1'b0;
        tx_data_d    = tx_data_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_typ_d = tx_par_typ_q;
        active_d     = active_q;
        err_d        = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_found && !bus.tx_busy) begin
                    ack_d[winner] = 1'b1;
                    tx_dv_d       = 1'b1;
                    active_d      = 1'b1;
                    tx_data_d     = win_data;
                    tx_par_en_d   = win_par_en;
                    tx_par_typ_d  = win_par_typ;
                    owner_d       = winner;
                    ptr_d         = winner;
                    cnt_d         = '0;
                    state_d       = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end else if (!tx_dv_q) begin
                    // The launch cycle itself is not a wait cycle: the transmitter has not
                    // sampled Data_Valid yet.
                    if (cnt_q == CntW'(Timeout - 1)) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    active_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ptr_q        <= IdxW'(NumReq - 1);
            owner_q      <= IdxW'(NumReq - 1);
            cnt_q        <= '0;
            ack_q        <= '0;
            tx_dv_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_par_en_q  <= 1'b0;
            tx_par_typ_q <= 1'b0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            tx_dv_q      <= tx_dv_d;
            tx_data_q    <= tx_data_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_typ_q <= tx_par_typ_d;
            active_q     <= active_d;
            err_q        <= err_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.tx_dv       = tx_dv_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_par_en   = tx_par_en_q;
    assign bus.tx_par_typ  = tx_par_typ_q;
    assign bus.owner       = owner_q;
    assign bus.active      = active_q;
    assign bus.err_timeout = err_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `UART_TX` instance between `NUM_REQ` byte producers. It sits directly in front of the transmitter and selects one pending requester. It latches that requester's byte and parity configuration, issues a single-cycle `Data_Valid` launch, and then tracks the transmitter's `busy` until the frame completes. If `busy` never rises after a launch, the arbiter times out and flags an error.

## Interface
- `NUM_REQ`, 4: number of requesters, minimum 2.
- `IDX_W`, `$clog2(NUM_REQ)`: width of the owner index.
- `TIMEOUT`, 4: maximum number of cycles spent waiting for `TX_BUSY` to rise after a launch, minimum 2.

- `CLK` in 1: single clock.
- `RST` in 1: synchronous, active-low reset.
- `REQ` in `NUM_REQ`: per-requester pending flag. Each requester holds it until its `ACK`.
- `REQ_DATA` in `8*NUM_REQ`: byte for requester i at `[8i+7:8i]`. Must be stable while `REQ[i]` is high.
- `REQ_PAR_EN` in `NUM_REQ`: per-requester parity enable.
- `REQ_PAR_TYP` in `NUM_REQ`: per-requester parity type (0 = even, 1 = odd).
- `TX_BUSY` in 1: `busy` from the transmitter.
- `ACK` out `NUM_REQ`: one-hot, one-cycle pulse. Marks the byte as consumed.
- `TX_DV` out 1: drives the transmitter's `Data_Valid`. One-cycle pulse.
- `TX_DATA` out 8: drives `P_DATA`. Holds the latched byte until the next grant.
- `TX_PAR_EN` out 1: drives `PAR_EN`. Latched per frame.
- `TX_PAR_TYP` out 1: drives `PAR_TYP`. Latched per frame.
- `OWNER` out `IDX_W`: index of the last granted requester.
- `ACTIVE` out 1: high from grant until frame completion or timeout.
- `ERR_TIMEOUT` out 1: one-cycle pulse when a launch is abandoned.

## Operation
- All outputs are registered.
- Reset values:
  - `ACK`=0, `TX_DV`=0, `TX_DATA`=0x00, `TX_PAR_EN`=0, `TX_PAR_TYP`=0.
  - `OWNER`=`NUM_REQ-1`, `ACTIVE`=0, `ERR_TIMEOUT`=0.
  - State = IDLE, round-robin pointer = `NUM_REQ-1`, timeout counter = 0.
- States are IDLE, WAIT_BUSY and WAIT_DONE.
- **IDLE**
  - Grants only when `REQ != 0` and `TX_BUSY == 0`.
  - Winner: the first set bit scanning from `ptr+1` upward, wrapping modulo `NUM_REQ`.
  - On grant, in the next cycle:
    - `ACK[w]`=1, `TX_DV`=1, `ACTIVE`=1.
    - `TX_DATA`, `TX_PAR_EN` and `TX_PAR_TYP` take requester w's values.
    - `OWNER`=w, `ptr`=w, counter cleared.
    - Next state is WAIT_BUSY.
  - If `TX_BUSY==1`, the arbiter stays in IDLE and grants nothing.
- **WAIT_BUSY**
  - `TX_BUSY==1` moves the state to WAIT_DONE.
  - Otherwise the counter increments.
  - When the counter reaches `TIMEOUT-1` with `TX_BUSY` still 0:
    - Next cycle: `ERR_TIMEOUT`=1, `ACTIVE`=0, state IDLE.
    - The byte stays consumed (no retry).
    - The pointer keeps the failed owner.
- **WAIT_DONE**
  - `TX_BUSY==0` causes `ACTIVE`=0 and a return to IDLE.
- `ACK` and `TX_DV` are never high for more than one consecutive cycle.
- At most one `ACK` bit is set at a time.
- Requests that change while not in IDLE have no effect until IDLE is re-entered.
- A requester that drops `REQ` before it is sampled in IDLE is not granted.
- Reset in any state forces the reset values on the next edge. An in-flight frame is abandoned from the arbiter's side, with no `ERR_TIMEOUT` pulse.

## Timing
- Grant latency: `REQ` sampled high in IDLE at edge n gives `ACK` and `TX_DV` high during cycle n+1.
- The transmitter samples `TX_DV` at edge n+1. `busy` is expected high from cycle n+2.
- Release latency: `TX_BUSY` sampled low in WAIT_DONE at edge m gives `ACTIVE` low in cycle m+1.
  - The earliest next grant is evaluated at edge m+1, with `ACK` in cycle m+2.
- Timeout: `ERR_TIMEOUT` occurs `TIMEOUT+1` cycles after the `TX_DV` cycle when `TX_BUSY` stays 0.
- Back-to-back frames from different requesters therefore have a 2-cycle gap between `busy` falling and the next `TX_DV`.

## Test plan
- **Single request:** Reset, then `REQ`=0001 with byte 0xA5, `PAR_EN`=1, `PAR_TYP`=0. Expect `ACK`=0001 and `TX_DV` for one cycle with `TX_DATA`=0xA5 and `TX_PAR_EN`=1. With a real `UART_TX` attached, the line carries 0xA5 with even parity. `ACTIVE` falls 1 cycle after `busy` falls.
- **Fairness:** Hold `REQ`=1111 continuously. Grants follow 0,1,2,3,0,… Exactly one `ACK` per frame, and no `TX_DV` while `busy`=1.
- **Pointer wrap:** Last owner 2, then `REQ`=0011. Expect a grant to 0 first, then 1.
- **Timeout:** Tie `TX_BUSY`=0 with `REQ`=0100. Expect `TX_DV`, then `ERR_TIMEOUT` 5 cycles later (`TIMEOUT`=4), then a return to IDLE. The next grant goes to requester 3 if it is pending.
- **Transmitter already busy:** Hold `TX_BUSY`=1 while `REQ`=0001. Expect no `ACK`. Release `busy` at cycle k and expect `ACK` in cycle k+1.
- **Reset mid-frame:** Assert `RST`=0 during WAIT_DONE. Expect all outputs at their reset values on the next edge, the pointer at `NUM_REQ-1`, and `REQ`=1111 granting requester 0 first.
